microwave_sequencer: RTL and testbench

//   Top-level cook sequencer for the microwave oven. It takes keypad time entry (MM:SS BCD), counts
//   the time down on a 1 Hz strobe and drives mag_on, with door interlock, pause and resume.
//   It also raises timer_done at the end of a cook. It sits above the magnetron latch logic and

---
 rtl/microwave_sequencer_pkg.sv | 30 +++
 rtl/microwave_sequencer_bcd_mmss_down.sv | 38 +++
 rtl/microwave_sequencer.sv | 147 ++++++++++++++
 tb/tb_microwave_sequencer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/microwave_sequencer_pkg.sv
// rtl/microwave_sequencer_pkg.sv - state encoding, display width and BCD field helpers for the cook sequencer
package microwave_sequencer_pkg;

    localparam int DISP_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SET   = 3'd1,
        ST_COOK  = 3'd2,
        ST_PAUSE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    function automatic logic [3:0] min_tens(input logic [DISP_W-1:0] d);
        return d[15:12];
    endfunction

    function automatic logic [3:0] min_ones(input logic [DISP_W-1:0] d);
        return d[11:8];
    endfunction

    function automatic logic [3:0] sec_tens(input logic [DISP_W-1:0] d);
        return d[7:4];
    endfunction

    function automatic logic [3:0] sec_ones(input logic [DISP_W-1:0] d);
        return d[3:0];
    endfunction

endpackage

// File: rtl/microwave_sequencer_bcd_mmss_down.sv
// rtl/microwave_sequencer_bcd_mmss_down.sv - combinational one-second decrement of a BCD MM:SS value
module bcd_mmss_down
    import microwave_sequencer_pkg::*;
(
    input  logic [DISP_W-1:0] din,
    output logic [DISP_W-1:0] dout,
    output logic              zero
);

    logic [3:0] mt, mo, st, so;

    // Seconds borrow through 0->5 on the tens digit, minutes through 0->9.
    always_comb begin
        mt = min_tens(din);
        mo = min_ones(din);
        st = sec_tens(din);
        so = sec_ones(din);
        if (so != 4'd0) begin
            so = so - 4'd1;
        end else begin
            so = 4'd9;
            if (st != 4'd0) begin
                st = st - 4'd1;
            end else begin
                st = 4'd5;
                if (mo != 4'd0) begin
                    mo = mo - 4'd1;
                end else begin
                    mo = 4'd9;
                    mt = (mt != 4'd0) ? mt - 4'd1 : 4'd9;
                end
            end
        end
        dout = {mt, mo, st, so};
        zero = (dout == '0);
    end

endmodule

// File: rtl/microwave_sequencer.sv
// rtl/microwave_sequencer.sv - cook sequencer: keypad entry, BCD countdown, door interlock, magnetron and done control
module microwave_sequencer
    import microwave_sequencer_pkg::*;
#(
    parameter int DONE_HOLD = 3,
    parameter int TW        = 3
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              tick_1hz,
    input  logic              startn,
    input  logic              stopn,
    input  logic              clearn,
    input  logic              door_closed,
    input  logic              digit_valid,
    input  logic [3:0]        digit,
    output logic              mag_on,
    output logic              timer_done,
    output logic [DISP_W-1:0] disp,
    output logic [2:0]        state
);

    state_t            state_q, state_d;
    logic [DISP_W-1:0] disp_q, disp_d, disp_dec;
    logic [TW-1:0]     hold_q, hold_d;
    logic              start_h, stop_h, clear_h;
    logic              mag_d, done_d, dec_zero;

    // Raw presses are 1->0 edges; only the highest-priority one is acted on.
    logic start_raw, stop_raw, clear_raw;
    logic start_p, stop_p, clear_p, any_press;
    logic digit_ok, can_start;

    assign start_raw = start_h & ~startn;
    assign stop_raw  = stop_h & ~stopn;
    assign clear_raw = clear_h & ~clearn;
    assign clear_p   = clear_raw;
    assign stop_p    = stop_raw & ~clear_raw;
    assign start_p   = start_raw & ~stop_raw & ~clear_raw;
    assign any_press = start_raw | stop_raw | clear_raw;

    assign digit_ok  = digit_valid && (digit <= 4'd9);
    assign can_start = door_closed && (disp_q != '0) && (sec_tens(disp_q) <= 4'd5);

    bcd_mmss_down u_dec (
        .din  (disp_q),
        .dout (disp_dec),
        .zero (dec_zero)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            disp_q     <= '0;
            hold_q     <= '0;
            mag_on     <= 1'b0;
            timer_done <= 1'b0;
            start_h    <= 1'b1;
            stop_h     <= 1'b1;
            clear_h    <= 1'b1;
        end else begin
            state_q    <= state_d;
            disp_q     <= disp_d;
            hold_q     <= hold_d;
            mag_on     <= mag_d;
            timer_done <= done_d;
            start_h    <= startn;
            stop_h     <= stopn;
            clear_h    <= clearn;
        end
    end

    always_comb begin
        state_d = state_q;
        disp_d  = disp_q;
        hold_d  = hold_q;
        case (state_q)
            ST_IDLE: begin
                if (digit_ok) begin
                    disp_d  = {disp_q[11:0], digit};
                    state_d = ST_SET;
                end
            end
            ST_SET: begin
                if (clear_p || stop_p) begin
                    disp_d  = '0;
                    state_d = ST_IDLE;
                end else if (start_p && can_start) begin
                    state_d = ST_COOK;
                end else if (digit_ok) begin
                    disp_d = {disp_q[11:0], digit};
                end
            end
            ST_COOK: begin
                if (clear_p) begin
                    disp_d  = '0;
                    state_d = ST_IDLE;
                end else if (!door_closed || stop_p) begin
                    state_d = ST_PAUSE;
                end else if (tick_1hz) begin
                    disp_d = disp_dec;
                    if (dec_zero) begin
                        state_d = ST_DONE;
                        hold_d  = '0;
                    end
                end
            end
            ST_PAUSE: begin
                if (clear_p || stop_p) begin
                    disp_d  = '0;
                    state_d = ST_IDLE;
                end else if (start_p && door_closed) begin
                    state_d = ST_COOK;
                end
            end
            ST_DONE: begin
                disp_d = '0;
                if (any_press) begin
                    state_d = ST_IDLE;
                    hold_d  = '0;
                end else if (tick_1hz) begin
                    if (hold_q == TW'(DONE_HOLD - 1)) begin
                        state_d = ST_IDLE;
                        hold_d  = '0;
                    end else begin
                        hold_d = hold_q + TW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                disp_d  = '0;
                hold_d  = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they track state_q exactly.
    always_comb begin
        mag_d  = (state_d == ST_COOK);
        done_d = (state_d == ST_DONE);
    end

    assign disp  = disp_q;
    assign state = state_q;

endmodule

// File: tb/tb_microwave_sequencer.sv
// tb/tb_microwave_sequencer.sv - scoreboard bench for microwave_sequencer against a seconds-based reference model
module tb_microwave_sequencer;

    localparam int S_IDLE = 0, S_SET = 1, S_COOK = 2, S_PAUSE = 3, S_DONE = 4;
    localparam int HOLD = 3;

    logic        clk = 1'b0;
    logic        rstn, tick_1hz, startn, stopn, clearn, door_closed, digit_valid;
    logic [3:0]  digit;
    logic        mag_on, timer_done;
    logic [15:0] disp;
    logic [2:0]  state;

    always #5 clk = ~clk;

    microwave_sequencer #(.DONE_HOLD(3), .TW(3)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .tick_1hz    (tick_1hz),
        .startn      (startn),
        .stopn       (stopn),
        .clearn      (clearn),
        .door_closed (door_closed),
        .digit_valid (digit_valid),
        .digit       (digit),
        .mag_on      (mag_on),
        .timer_done  (timer_done),
        .disp        (disp),
        .state       (state)
    );

    typedef struct packed {
        logic [2:0]  st;
        logic [15:0] disp;
        logic        mag;
        logic        done;
    } snap_t;

    snap_t exp_q[$];
    int    checks = 0;
    int    failures = 0;

    int m_st;
    int m_dig[4];
    int m_hold;
    bit h_s, h_p, h_c;
    bit door_lvl;

    function automatic int to_secs();
        return (m_dig[0] * 10 + m_dig[1]) * 60 + m_dig[2] * 10 + m_dig[3];
    endfunction

    task automatic set_secs(input int s);
        m_dig[0] = (s / 60) / 10;
        m_dig[1] = (s / 60) % 10;
        m_dig[2] = (s % 60) / 10;
        m_dig[3] = s % 10;
    endtask

    task automatic model_reset();
        m_st = S_IDLE;
        set_secs(0);
        m_hold = 0;
        h_s = 1; h_p = 1; h_c = 1;
    endtask

    function automatic snap_t snap();
        snap_t r;
        r.st   = 3'(m_st);
        r.disp = {4'(m_dig[0]), 4'(m_dig[1]), 4'(m_dig[2]), 4'(m_dig[3])};
        r.mag  = (m_st == S_COOK);
        r.done = (m_st == S_DONE);
        return r;
    endfunction

    task automatic model_step(input bit s, input bit p, input bit c, input bit d,
                              input bit v, input logic [3:0] g, input bit t);
        bit cp  = h_c && !c;
        bit pp  = h_p && !p;
        bit sp  = h_s && !s;
        bit stp = pp && !cp;
        bit sta = sp && !pp && !cp;
        bit dok = v && (g <= 4'd9);
        int secs;
        h_s = s; h_p = p; h_c = c;
        case (m_st)
            S_IDLE: if (dok) begin
                m_dig[0] = m_dig[1]; m_dig[1] = m_dig[2]; m_dig[2] = m_dig[3]; m_dig[3] = int'(g);
                m_st = S_SET;
            end
            S_SET: begin
                if (cp || stp) begin
                    set_secs(0); m_st = S_IDLE;
                end else if (sta && d && to_secs() != 0 && m_dig[2] <= 5) begin
                    m_st = S_COOK;
                end else if (dok) begin
                    m_dig[0] = m_dig[1]; m_dig[1] = m_dig[2]; m_dig[2] = m_dig[3]; m_dig[3] = int'(g);
                end
            end
            S_COOK: begin
                if (cp) begin
                    set_secs(0); m_st = S_IDLE;
                end else if (!d || stp) begin
                    m_st = S_PAUSE;
                end else if (t) begin
                    secs = to_secs() - 1;
                    set_secs(secs);
                    if (secs == 0) begin m_st = S_DONE; m_hold = 0; end
                end
            end
            S_PAUSE: begin
                if (cp || stp) begin
                    set_secs(0); m_st = S_IDLE;
                end else if (sta && d) begin
                    m_st = S_COOK;
                end
            end
            default: begin
                if (cp || pp || sp) begin
                    m_st = S_IDLE; m_hold = 0;
                end else if (t) begin
                    m_hold++;
                    if (m_hold == HOLD) begin m_st = S_IDLE; m_hold = 0; end
                end
            end
        endcase
    endtask

    task automatic idle_inputs();
        startn = 1; stopn = 1; clearn = 1; digit_valid = 0; digit = 4'd0; tick_1hz = 0;
        door_closed = door_lvl;
    endtask

    task automatic act(input bit s, input bit p, input bit c, input bit v,
                       input logic [3:0] g, input bit t);
        @(posedge clk); #2;
        startn = s; stopn = p; clearn = c; door_closed = door_lvl;
        digit_valid = v; digit = g; tick_1hz = t;
        model_step(s, p, c, door_lvl, v, g, t);
        exp_q.push_back(snap());
    endtask

    task automatic nop();                  act(1, 1, 1, 0, 4'd0, 0); endtask
    task automatic key(input logic [3:0] g); act(1, 1, 1, 1, g, 0);  endtask
    task automatic press_start();          act(0, 1, 1, 0, 4'd0, 0); endtask
    task automatic press_stop();           act(1, 0, 1, 0, 4'd0, 0); endtask
    task automatic press_clear();          act(1, 1, 0, 0, 4'd0, 0); endtask
    task automatic tick();                 act(1, 1, 1, 0, 4'd0, 1); endtask

    task automatic check_reset(input string name);
        checks++;
        if ({state, disp, mag_on, timer_done} !== 21'd0) begin
            failures++;
            $display("FAIL %s: got st=%0d disp=%h mag=%b done=%b, expected all zero",
                     name, state, disp, mag_on, timer_done);
        end
    endtask

    task automatic async_reset();
        @(posedge clk); #3;
        rstn = 0;
        idle_inputs();
        #1 check_reset("async_reset_mid_cycle");
        model_reset();
        @(posedge clk); #2;
        rstn = 1;
    endtask

    // Monitor: compares every cycle for which the stimulus side queued an expectation.
    initial begin
        snap_t e, a;
        forever begin
            @(posedge clk); #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {state, disp, mag_on, timer_done};
                checks++;
                if (a !== e) begin
                    failures++;
                    $display("FAIL cycle_state @%0t: got st=%0d disp=%h mag=%b done=%b, expected st=%0d disp=%h mag=%b done=%b",
                             $time, a.st, a.disp, a.mag, a.done, e.st, e.disp, e.mag, e.done);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        door_lvl = 1;
        rstn = 0;
        idle_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1 check_reset("reset_state");
        #1 rstn = 1;

        // 12 s cook to done, done hold, back to idle
        key(0); key(0); key(1); key(2);
        press_start();
        repeat (12) begin tick(); nop(); end
        repeat (3) begin tick(); nop(); end
        nop();

        // borrow chains
        press_clear();
        key(0); key(1); key(0); key(0); press_start(); tick(); nop(); press_clear();
        key(1); key(0); key(0); key(0); press_start(); tick(); nop(); press_clear();

        // door interlock and resume
        key(0); key(0); key(3); key(0); press_start(); nop();
        door_lvl = 0; tick(); nop();
        press_start(); nop();
        door_lvl = 1; nop();
        press_start(); press_start(); tick(); nop(); press_clear();

        // simultaneous stop+start, rejected starts
        key(1); key(2); act(0, 0, 1, 0, 4'd0, 0); nop();
        key(0); key(0); key(7); key(5); press_start(); nop(); press_clear();
        key(0); key(0); press_start(); nop(); press_clear();

        // stop in cook then stop in pause; early exit from done
        key(5); press_start(); tick(); press_stop(); nop(); press_stop(); nop();
        key(0); key(0); key(0); key(2); press_start(); tick(); tick(); nop();
        press_start(); nop();

        // shift-out, ignored digit, async reset mid-cook
        key(1); key(2); key(3); key(4); key(5); key(4'hA);
        press_start(); tick(); tick();
        async_reset();

        for (int i = 0; i < 3000; i++) begin
            door_lvl = ($urandom_range(0, 19) != 0);
            act($urandom_range(0, 11) != 0, $urandom_range(0, 23) != 0,
                $urandom_range(0, 39) != 0, $urandom_range(0, 2) == 0,
                4'($urandom_range(0, 11)), $urandom_range(0, 1) == 1);
            if (i == 1500) async_reset();
        end

        @(posedge clk); #5;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL queue_drain: got %0d pending, expected 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
